// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, defaults and packing helper for the matrix multiply engine
// Purpose: controller state encoding, default geometry and flat-bus element offset.
// Ports: none (package).
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 16;

  // Bit offset of element [i][j] in a row-major flat matrix bus.
  function automatic int elem_off(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/matmul_dot_unit.sv
// rtl/matmul_dot_unit.sv - combinational N-term dot product truncated to W bits
// Purpose: one row of A times one column of B, N parallel W x W -> 2W multipliers.
// Ports:
//   row_i  N*W  row vector A[i][*], element k at bits k*W +: W
//   col_i  N*W  column vector B[*][j], element k at bits k*W +: W
//   dot_o  W    sum of products modulo 2^W
module matmul_dot_unit #(
  parameter int N      = 4,
  parameter int W      = 16,
  parameter int SIGNED = 0
) (
  input  logic [N*W-1:0] row_i,
  input  logic [N*W-1:0] col_i,
  output logic [W-1:0]   dot_o
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] sum;
  logic [W-1:0]   sum_unused_hi;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    prod  = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (SIGNED != 0) begin
        a_ext = {{W{row_i[k*W+W-1]}}, row_i[k*W +: W]};
        b_ext = {{W{col_i[k*W+W-1]}}, col_i[k*W +: W]};
      end else begin
        a_ext = {{W{1'b0}}, row_i[k*W +: W]};
        b_ext = {{W{1'b0}}, col_i[k*W +: W]};
      end
      prod = a_ext * b_ext;
      sum  = sum + prod;
    end
  end

  // Only the low W bits survive; the wrap is intentional.
  assign dot_o         = sum[W-1:0];
  assign sum_unused_hi = sum[2*W-1:W];

endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - clocked N x N matrix multiply / multiply-accumulate engine
// Purpose: takes A then B over a valid/ready input, computes C = A x B (or C += A x B),
//          one element per cycle, and holds C on a valid/ready output.
// Ports:
//   clk, nReset           clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; first transfer is A, second is B
//   in_data  N*N*W        operand, element [i][j] at bits (i*N+j)*W +: W
//   in_acc                sampled with A: 1 = accumulate into held C
//   out_valid/out_ready   result handshake
//   out_data N*N*W        result C, same packing
//   busy                  not idle
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int W      = DEF_W,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] in_data,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out_data,
  output logic             busy
);

  localparam int NN  = N * N;
  localparam int BUS = NN * W;
  localparam int EW  = $clog2(NN + 1);
  localparam logic [EW-1:0] LAST_E = EW'(NN);

  state_t         state_q, state_d;
  logic [EW-1:0]  e_q, e_d;
  logic [BUS-1:0] a_q, b_q, c_q;
  logic           acc_q;
  logic [W-1:0]   dot_q, dot_w;
  logic [N*W-1:0] row_w, col_w;
  logic           take_a, take_b, c_we;
  int             rd_i, rd_j, wr_off;

  // e_q doubles as pipeline position: the dot for element e is registered while
  // e_q == e and written into C one cycle later, so e_q runs 0..N*N.
  always_comb begin
    rd_i   = 0;
    rd_j   = 0;
    wr_off = 0;
    row_w  = '0;
    col_w  = '0;
    if (e_q < LAST_E) begin
      rd_i = int'(e_q) / N;
      rd_j = int'(e_q) % N;
    end
    if (e_q != '0) begin
      wr_off = (int'(e_q) - 1) * W;
    end
    for (int k = 0; k < N; k++) begin
      row_w[k*W +: W] = a_q[elem_off(rd_i, k, N, W) +: W];
      col_w[k*W +: W] = b_q[elem_off(k, rd_j, N, W) +: W];
    end
  end

  matmul_dot_unit #(.N(N), .W(W), .SIGNED(SIGNED)) u_dot (
    .row_i (row_w),
    .col_i (col_w),
    .dot_o (dot_w)
  );

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    take_a    = 1'b0;
    take_b    = 1'b0;
    c_we      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          take_a  = 1'b1;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          take_b  = 1'b1;
          e_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        c_we = (e_q != '0);
        e_d  = e_q + 1'b1;
        if (e_q == LAST_E) begin
          e_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      acc_q <= 1'b0;
      dot_q <= '0;
    end else begin
      if (take_a) begin
        a_q   <= in_data;
        acc_q <= in_acc;
      end
      if (take_b) b_q <= in_data;
      if (state_q == COMPUTE) dot_q <= dot_w;
      if (c_we) begin
        c_q[wr_off +: W] <= acc_q ? (c_q[wr_off +: W] + dot_q) : dot_q;
      end
    end
  end

  assign out_data = c_q;

endmodule
